// File: rtl/idex_issue.sv
// In-order issue stage between decode and the EX reservation stations.
// Decoded instructions wait in a small FIFO. Their pending operands capture ROB
// broadcasts. The head entry issues when its target unit has room.
module idex_issue #(
  parameter int TAG_W    = 5,
  parameter int DATA_W   = 32,
  parameter int OP_W     = 6,
  parameter int UNIT_NUM = 2,
  parameter int UNIT_W   = 1,
  parameter int DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  logic [UNIT_W-1:0]   dec_unit,
  input  logic [TAG_W-1:0]    dec_target,
  input  logic [OP_W-1:0]     dec_op,
  input  logic [TAG_W-1:0]    dec_tag1,
  input  logic [TAG_W-1:0]    dec_tag2,
  input  logic [DATA_W-1:0]   dec_val1,
  input  logic [DATA_W-1:0]   dec_val2,
  input  logic                bc_valid,
  input  logic [TAG_W-1:0]    bc_tag,
  input  logic [DATA_W-1:0]   bc_val,
  input  logic [UNIT_NUM-1:0] full,
  output logic                ex_ce,
  output logic [UNIT_W-1:0]   ex_unit,
  output logic [TAG_W-1:0]    ex_target,
  output logic [OP_W-1:0]     ex_op,
  output logic [TAG_W-1:0]    ex_tag1,
  output logic [TAG_W-1:0]    ex_tag2,
  output logic [DATA_W-1:0]   ex_val1,
  output logic [DATA_W-1:0]   ex_val2
);

  localparam logic [TAG_W-1:0] TAG_INVALID = '1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } opnd_t;

  typedef struct packed {
    logic [UNIT_W-1:0] unit;
    logic [TAG_W-1:0]  target;
    logic [OP_W-1:0]   op;
    opnd_t             src1;
    opnd_t             src2;
  } entry_t;

  // A pending operand whose producer is broadcasting picks up the result.
  // Operands that are already valid are never touched, even if bc_tag is all-ones.
  function automatic opnd_t snoop(input opnd_t o, input logic bv,
                                  input logic [TAG_W-1:0] bt,
                                  input logic [DATA_W-1:0] bval);
    opnd_t r;
    r = o;
    if (bv && (o.tag != TAG_INVALID) && (o.tag == bt)) begin
      r.tag = TAG_INVALID;
      r.val = bval;
    end
    return r;
  endfunction

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ex_ce_q, ex_ce_d;
  entry_t            ex_q, ex_d;

  entry_t            head;
  entry_t            new_entry;
  logic              head_valid;
  logic              unit_full;
  logic              unit_ok;
  logic              push;
  logic              pop;

  // Next-state: FIFO bookkeeping, operand snooping and issue selection.
  always_comb begin
    head       = mem_q[rd_ptr_q];
    head_valid = (count_q != '0);

    // An out-of-range unit index never sees room, so such an entry stalls for good.
    unit_full = 1'b1;
    unit_ok   = 1'b0;
    for (int i = 0; i < UNIT_NUM; i++) begin
      if (head.unit == UNIT_W'(i)) begin
        unit_full = full[i];
        unit_ok   = 1'b1;
      end
    end

    // Readiness depends only on occupancy; a simultaneous pop never frees a slot early.
    dec_ready = (count_q < CNT_W'(DEPTH));
    push      = dec_valid && dec_ready && !flush;
    pop       = head_valid && !unit_full && !flush;

    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i]      = mem_q[i];
      mem_d[i].src1 = snoop(mem_q[i].src1, bc_valid, bc_tag, bc_val);
      mem_d[i].src2 = snoop(mem_q[i].src2, bc_valid, bc_tag, bc_val);
    end

    new_entry.unit     = dec_unit;
    new_entry.target   = dec_target;
    new_entry.op       = dec_op;
    new_entry.src1     = snoop('{tag: dec_tag1, val: dec_val1}, bc_valid, bc_tag, bc_val);
    new_entry.src2     = snoop('{tag: dec_tag2, val: dec_val2}, bc_valid, bc_tag, bc_val);
    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
    end

    ex_ce_d = pop;
    ex_d    = ex_q;
    if (pop) begin
      ex_d      = head;
      ex_d.src1 = snoop(head.src1, bc_valid, bc_tag, bc_val);
      ex_d.src2 = snoop(head.src2, bc_valid, bc_tag, bc_val);
    end

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO payload storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Control state and the registered issue interface.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      ex_ce_q        <= 1'b0;
      ex_q.unit      <= '0;
      ex_q.target    <= TAG_INVALID;
      ex_q.op        <= '0;
      ex_q.src1.tag  <= TAG_INVALID;
      ex_q.src1.val  <= '0;
      ex_q.src2.tag  <= TAG_INVALID;
      ex_q.src2.val  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ex_ce_q  <= ex_ce_d;
      ex_q     <= ex_d;
    end
  end

  assign ex_ce     = ex_ce_q;
  assign ex_unit   = ex_q.unit;
  assign ex_target = ex_q.target;
  assign ex_op     = ex_q.op;
  assign ex_tag1   = ex_q.src1.tag;
  assign ex_val1   = ex_q.src1.val;
  assign ex_tag2   = ex_q.src2.tag;
  assign ex_val2   = ex_q.src2.val;

  // A head entry aimed at a nonexistent unit would block the stage forever.
  a_unit_in_range: assert property (@(posedge clk) disable iff (!rst) head_valid |-> unit_ok);

endmodule

// File: tb/tb_idex_issue.sv
// Directed bench for idex_issue: stimulus queues expected issues, a monitor
// compares every ex_ce strobe against the queue in order.
module tb_idex_issue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [0:0]  dec_unit;
  logic [4:0]  dec_target;
  logic [5:0]  dec_op;
  logic [4:0]  dec_tag1, dec_tag2;
  logic [31:0] dec_val1, dec_val2;
  logic        bc_valid;
  logic [4:0]  bc_tag;
  logic [31:0] bc_val;
  logic [1:0]  full;
  logic        ex_ce;
  logic [0:0]  ex_unit;
  logic [4:0]  ex_target;
  logic [5:0]  ex_op;
  logic [4:0]  ex_tag1, ex_tag2;
  logic [31:0] ex_val1, ex_val2;

  typedef struct packed {
    logic [0:0]  unit;
    logic [4:0]  target;
    logic [5:0]  op;
    logic [4:0]  tag1;
    logic [31:0] val1;
    logic [4:0]  tag2;
    logic [31:0] val2;
  } rec_t;

  rec_t sb[$];
  rec_t got_r, exp_r;
  int   st_vec, st_err, mon_vec, mon_err;

  idex_issue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_unit(dec_unit), .dec_target(dec_target), .dec_op(dec_op),
    .dec_tag1(dec_tag1), .dec_tag2(dec_tag2),
    .dec_val1(dec_val1), .dec_val2(dec_val2),
    .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_val(bc_val),
    .full(full),
    .ex_ce(ex_ce), .ex_unit(ex_unit), .ex_target(ex_target), .ex_op(ex_op),
    .ex_tag1(ex_tag1), .ex_tag2(ex_tag2), .ex_val1(ex_val1), .ex_val2(ex_val2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    st_vec++;
    if (got !== want) begin
      st_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic set_dec(input logic [0:0] u, input logic [4:0] tg, input logic [5:0] op,
                         input logic [4:0] t1, input logic [31:0] v1,
                         input logic [4:0] t2, input logic [31:0] v2);
    dec_unit = u; dec_target = tg; dec_op = op;
    dec_tag1 = t1; dec_val1 = v1; dec_tag2 = t2; dec_val2 = v2;
  endtask

  task automatic push(input logic [0:0] u, input logic [4:0] tg, input logic [5:0] op,
                      input logic [4:0] t1, input logic [31:0] v1,
                      input logic [4:0] t2, input logic [31:0] v2);
    set_dec(u, tg, op, t1, v1, t2, v2);
    dec_valid = 1'b1;
    step();
    dec_valid = 1'b0;
  endtask

  task automatic expect_rec(input logic [0:0] u, input logic [4:0] tg, input logic [5:0] op,
                            input logic [4:0] t1, input logic [31:0] v1,
                            input logic [4:0] t2, input logic [31:0] v2);
    rec_t r;
    r = {u, tg, op, t1, v1, t2, v2};
    sb.push_back(r);
  endtask

  // Monitor: every issue strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && ex_ce) begin
      got_r = {ex_unit, ex_target, ex_op, ex_tag1, ex_val1, ex_tag2, ex_val2};
      mon_vec++;
      if (sb.size() == 0) begin
        mon_err++;
        $display("FAIL unexpected_issue: got %h expected no issue", got_r);
      end else begin
        exp_r = sb.pop_front();
        if (got_r !== exp_r) begin
          mon_err++;
          $display("FAIL issue_fields: got %h expected %h", got_r, exp_r);
        end
      end
    end
  end

  initial begin
    st_vec = 0; st_err = 0; mon_vec = 0; mon_err = 0;
    rst = 1'b0; flush = 1'b0; dec_valid = 1'b0;
    set_dec(1'b0, 5'd0, 6'd0, 5'h1F, 32'd0, 5'h1F, 32'd0);
    bc_valid = 1'b0; bc_tag = 5'd0; bc_val = 32'd0; full = 2'b00;

    // Reset state
    step(); step();
    chk("rst_ex_ce",     64'(ex_ce),     64'd0);
    chk("rst_ex_tag1",   64'(ex_tag1),   64'h1F);
    chk("rst_ex_tag2",   64'(ex_tag2),   64'h1F);
    chk("rst_ex_target", 64'(ex_target), 64'h1F);
    chk("rst_ex_val1",   64'(ex_val1),   64'd0);
    rst = 1'b1;
    step();
    chk("rst_dec_ready", 64'(dec_ready), 64'd1);

    // Single issue, latency and one-cycle strobe
    expect_rec(1'b0, 5'd3, 6'd5, 5'h1F, 32'h10, 5'h1F, 32'h20);
    push(1'b0, 5'd3, 6'd5, 5'h1F, 32'h10, 5'h1F, 32'h20);
    chk("lat_not_early", 64'(ex_ce), 64'd0);
    step();
    chk("lat_ce",        64'(ex_ce),     64'd1);
    chk("lat_target",    64'(ex_target), 64'd3);
    step();
    chk("lat_ce_drop",   64'(ex_ce), 64'd0);

    // Stall fills the FIFO, then back-to-back issue
    full = 2'b01;
    expect_rec(1'b0, 5'd1, 6'd2, 5'h1F, 32'h11, 5'h1F, 32'h12);
    expect_rec(1'b0, 5'd2, 6'd2, 5'h1F, 32'h21, 5'h1F, 32'h22);
    push(1'b0, 5'd1, 6'd2, 5'h1F, 32'h11, 5'h1F, 32'h12);
    push(1'b0, 5'd2, 6'd2, 5'h1F, 32'h21, 5'h1F, 32'h22);
    chk("full_dec_ready", 64'(dec_ready), 64'd0);
    chk("stall_no_ce",    64'(ex_ce),     64'd0);
    push(1'b0, 5'h1E, 6'd2, 5'h1F, 32'hEE, 5'h1F, 32'hEE);   // offered while full: dropped
    chk("stall_no_ce2",   64'(ex_ce),     64'd0);
    full = 2'b00;
    step();
    chk("b2b_first",  64'(ex_target), 64'd1);
    step();
    chk("b2b_ce2",    64'(ex_ce),     64'd1);
    chk("b2b_second", 64'(ex_target), 64'd2);
    step();
    chk("b2b_done",   64'(ex_ce),     64'd0);

    // Broadcast captured while stalled
    full = 2'b01;
    expect_rec(1'b0, 5'd4, 6'd1, 5'h1F, 32'hAB, 5'h1F, 32'h55);
    push(1'b0, 5'd4, 6'd1, 5'd7, 32'd0, 5'h1F, 32'h55);
    bc_valid = 1'b1; bc_tag = 5'd7; bc_val = 32'hAB;
    step();
    bc_valid = 1'b0;
    full = 2'b00;
    step();
    chk("snoop_stalled_val1", 64'(ex_val1), 64'hAB);
    step();

    // Broadcast on the accept edge
    full = 2'b01;
    expect_rec(1'b0, 5'd5, 6'd1, 5'h1F, 32'hAB, 5'h1F, 32'h66);
    bc_valid = 1'b1; bc_tag = 5'd7; bc_val = 32'hAB;
    push(1'b0, 5'd5, 6'd1, 5'd7, 32'd0, 5'h1F, 32'h66);
    bc_valid = 1'b0;
    full = 2'b00;
    step();
    chk("snoop_accept_tag1", 64'(ex_tag1), 64'h1F);
    step();

    // Broadcast on the issue edge; a non-matching pending tag leaves untouched
    expect_rec(1'b1, 5'd6, 6'd2, 5'h0A, 32'h77, 5'h1F, 32'hCD);
    push(1'b1, 5'd6, 6'd2, 5'h0A, 32'h77, 5'd9, 32'd0);
    bc_valid = 1'b1; bc_tag = 5'd9; bc_val = 32'hCD;
    step();
    bc_valid = 1'b0;
    chk("snoop_issue_val2", 64'(ex_val2), 64'hCD);
    step();

    // Head-of-line blocking across units
    full = 2'b01;
    expect_rec(1'b0, 5'd8, 6'd3, 5'h1F, 32'h1, 5'h1F, 32'h2);
    expect_rec(1'b1, 5'd9, 6'd4, 5'h1F, 32'h3, 5'h1F, 32'h4);
    push(1'b0, 5'd8, 6'd3, 5'h1F, 32'h1, 5'h1F, 32'h2);
    push(1'b1, 5'd9, 6'd4, 5'h1F, 32'h3, 5'h1F, 32'h4);
    step();
    chk("hol_blocked", 64'(ex_ce), 64'd0);
    full = 2'b00;
    step();
    chk("hol_first",  64'(ex_target), 64'd8);
    step();
    chk("hol_second", 64'(ex_target), 64'd9);
    step();

    // Flush discards buffered entries and the concurrent offer
    full = 2'b01;
    push(1'b0, 5'd10, 6'd1, 5'h1F, 32'h0, 5'h1F, 32'h0);
    push(1'b0, 5'd11, 6'd1, 5'h1F, 32'h0, 5'h1F, 32'h0);
    set_dec(1'b0, 5'd12, 6'd1, 5'h1F, 32'h0, 5'h1F, 32'h0);
    flush = 1'b1; dec_valid = 1'b1;
    step();
    flush = 1'b0; dec_valid = 1'b0;
    chk("flush_no_ce",     64'(ex_ce),     64'd0);
    chk("flush_dec_ready", 64'(dec_ready), 64'd1);
    full = 2'b00;
    step();
    chk("flush_empty", 64'(ex_ce), 64'd0);
    step();
    expect_rec(1'b0, 5'd13, 6'd7, 5'h1F, 32'hBEEF, 5'h1F, 32'hCAFE);
    push(1'b0, 5'd13, 6'd7, 5'h1F, 32'hBEEF, 5'h1F, 32'hCAFE);
    step();
    chk("post_flush_ce",     64'(ex_ce),     64'd1);
    chk("post_flush_target", 64'(ex_target), 64'd13);

    // Drain: every expected issue must have appeared
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", st_vec + mon_vec, st_err + mon_err);
    $finish;
  end

endmodule
